// File: rtl/microcode_sequencer_pkg.sv
// Shared types for the microcode sequencer: control word, ALU flags, micro-instruction
// layout, sequencing opcodes and sequencer states.
package microcode_sequencer_pkg;

  // Default micro-step counter width; micro_instr_t.target is sized from it.
  localparam int unsigned STEP_WIDTH_DEFAULT = 4;

  // Control word driven to the datapath, one per micro-step.
  typedef struct packed {
    logic       reset;   // abort instruction, clear sequencer and fault
    logic       halt;    // stop after this step
    logic       alu_en;
    logic [2:0] alu_op;
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       pc_inc;
  } control_word_t;

  // Registered ALU flags from the datapath.
  typedef struct packed {
    logic alu_zero;
    logic alu_carry;
    logic alu_neg;
    logic alu_ovf;
  } alu_flag_t;

  typedef enum logic [1:0] {
    SEQ_NEXT = 2'd0,
    SEQ_END  = 2'd1,
    SEQ_BRZ  = 2'd2,
    SEQ_BRC  = 2'd3
  } seq_op_e;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ROM   = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } seq_state_e;

  // One microcode ROM word.
  typedef struct packed {
    control_word_t                 cw;
    seq_op_e                       seq;
    logic [STEP_WIDTH_DEFAULT-1:0] target;
  } micro_instr_t;

endpackage

// File: rtl/microcode_sequencer_if.sv
// Instruction-byte ready/valid handshake between the bus (master) and the
// sequencer (slave).
//   instr       : instruction byte
//   instr_valid : byte is valid
//   instr_ready : sequencer accepts the byte this cycle
interface microcode_sequencer_if #(
  parameter int unsigned DATA_BUS_WIDTH = 8
);
  logic [DATA_BUS_WIDTH-1:0] instr;
  logic                      instr_valid;
  logic                      instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: accepts an instruction byte over instr_bus, then walks that
// opcode's micro-steps in an external synchronous ROM, emitting one control word
// per step. Supports conditional micro-branches, halt/resume and a sticky
// step-overflow fault.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   instr_bus    : instruction handshake (slave side)
//   mc_addr_o    : ROM address {opcode, step}
//   mc_data_i    : ROM data, valid one cycle after its address
//   flags_i      : registered ALU flags
//   halt_req_i   : halt request, sampled only between instructions
//   run_i        : resume pulse, honoured only while halted
//   cw_o/cw_valid_o : control word and its qualifier
//   step_o, halt_o, fault_o : debug step, halted status, sticky overflow fault
module microcode_sequencer
  import microcode_sequencer_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = 8,
  parameter int unsigned OPCODE_WIDTH   = 4,
  parameter int unsigned STEP_WIDTH     = STEP_WIDTH_DEFAULT,
  parameter int unsigned MC_ADDR_WIDTH  = OPCODE_WIDTH + STEP_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  microcode_sequencer_if.slave     instr_bus,
  output logic [MC_ADDR_WIDTH-1:0] mc_addr_o,
  input  micro_instr_t             mc_data_i,
  input  alu_flag_t                flags_i,
  input  logic                     halt_req_i,
  input  logic                     run_i,
  output control_word_t            cw_o,
  output logic                     cw_valid_o,
  output logic [STEP_WIDTH-1:0]    step_o,
  output logic                     halt_o,
  output logic                     fault_o
);

  seq_state_e              state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [STEP_WIDTH-1:0]   step_q, step_d;
  logic                    fault_q, fault_d;
  logic                    instr_ready;

  // Only the opcode field and the zero/carry flags steer sequencing.
  logic unused_inputs;
  assign unused_inputs = ^{flags_i.alu_neg, flags_i.alu_ovf,
                           instr_bus.instr[DATA_BUS_WIDTH-OPCODE_WIDTH-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
      step_q   <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      step_q   <= step_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    step_d      = step_q;
    fault_d     = fault_q;
    instr_ready = 1'b0;
    cw_o        = '0;
    cw_valid_o  = 1'b0;
    halt_o      = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        instr_ready = !halt_req_i;
        if (halt_req_i) begin
          state_d = S_HALT;
        end else if (instr_bus.instr_valid) begin
          opcode_d = instr_bus.instr[DATA_BUS_WIDTH-1 -: OPCODE_WIDTH];
          step_d   = '0;
          state_d  = S_ROM;
        end
      end

      S_ROM: state_d = S_EXEC;

      S_EXEC: begin
        cw_o       = mc_data_i.cw;
        cw_valid_o = 1'b1;
        if (mc_data_i.cw.reset) begin
          opcode_d = '0;
          step_d   = '0;
          fault_d  = 1'b0;
          state_d  = S_FETCH;
        end else if (mc_data_i.cw.halt) begin
          state_d = S_HALT;
        end else if (mc_data_i.seq == SEQ_END) begin
          state_d = S_FETCH;
        end else if ((mc_data_i.seq == SEQ_BRZ && flags_i.alu_zero) ||
                     (mc_data_i.seq == SEQ_BRC && flags_i.alu_carry)) begin
          // Taken branch: jumps anywhere, never faults.
          step_d  = STEP_WIDTH'(mc_data_i.target);
          state_d = S_ROM;
        end else if (step_q == {STEP_WIDTH{1'b1}}) begin
          // Increment past the last step: fault instead of wrapping.
          fault_d = 1'b1;
          step_d  = '0;
          state_d = S_HALT;
        end else begin
          step_d  = step_q + 1'b1;
          state_d = S_ROM;
        end
      end

      S_HALT: begin
        halt_o = 1'b1;
        if (run_i) state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

  assign instr_bus.instr_ready = instr_ready;
  assign mc_addr_o             = MC_ADDR_WIDTH'({opcode_q, step_q});
  assign step_o                = step_q;
  assign fault_o               = fault_q;

endmodule
